// File: rtl/common_pkg.sv
// Shared arbitration types and the thermometer helper used to build
// round-robin priority masks.
package common_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_e;

    // Widest requester vector the thermometer helper supports.
    localparam int THERMO_W = 64;

    // UIntToThermo: prefix-OR from bit 0 upward, so every bit at or above the
    // lowest set input bit becomes one.
    function automatic logic [THERMO_W-1:0] uint_to_thermo(input logic [THERMO_W-1:0] x);
        logic [THERMO_W-1:0] t;
        t[0] = x[0];
        for (int i = 1; i < THERMO_W; i++) begin
            t[i] = t[i-1] | x[i];
        end
        return t;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: masks off requesters at or below the last
// winner, then priority-encodes the lowest remaining index.
module rr_pick
    import common_pkg::*;
#(
    parameter int NUM_REQ = 8,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic               any,
    output logic [IDW-1:0]     winner
);

    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] cand;

    // The mask bits above NUM_REQ-1 are dropped, so ptr = NUM_REQ-1 yields an
    // empty mask and the search falls back to plain lowest-index priority.
    always_comb begin
        mask   = NUM_REQ'(uint_to_thermo((THERMO_W'(1) << ptr) << 1));
        masked = req & mask;
        cand   = (|masked) ? masked : req;
        any    = |req;
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand[i]) winner = IDW'(i);
        end
    end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter: shares one valid/ready channel among NUM_REQ
// requesters, locking the grant for a whole packet until its last beat.
module rr_packet_arbiter
    import common_pkg::*;
#(
    parameter int NUM_REQ = 8,
    parameter int DATA_W  = 32,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    output logic [IDW-1:0]            out_id,
    input  logic                      out_ready
);

    arb_state_e     state;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] ptr;
    logic           any_valid;
    logic [IDW-1:0] winner;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr),
        .any    (any_valid),
        .winner (winner)
    );

    // Datapath is a pure mux on the locked grant; only BUSY exposes it.
    always_comb begin
        out_id    = gnt_id;
        out_data  = req_data[int'(gnt_id)*DATA_W +: DATA_W];
        out_valid = 1'b0;
        out_last  = 1'b0;
        req_ready = '0;
        if (state == BUSY) begin
            out_valid         = req_valid[gnt_id];
            out_last          = req_last[gnt_id];
            req_ready[gnt_id] = out_ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gnt_id <= '0;
            ptr    <= IDW'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        gnt_id <= winner;
                        ptr    <= winner;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (out_valid && out_ready && out_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Self-checking bench for rr_packet_arbiter: per-requester source queues,
// a circular-search arbitration model and directed plus random phases.
module tb_rr_packet_arbiter;

    localparam int N  = 8;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [2:0]      out_id;
    logic            out_ready;

    int checks   = 0;
    int failures = 0;

    // Pending beats per requester: bit DW is the last flag.
    logic [DW:0] srcq [N][$];
    logic [N-1:0] en;
    int          sent [N];
    int          dut_rx [N];
    int          dut_ids [$];

    bit m_busy;
    int m_gnt;
    int m_ptr;

    rr_packet_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sendPacket(input int id, input int beats);
        for (int b = 0; b < beats; b++) begin
            srcq[id].push_back({(b == beats - 1), DW'($urandom)});
        end
        sent[id] += beats;
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            if (en[i] && srcq[i].size() > 0) begin
                req_valid[i]           = 1'b1;
                req_data[i*DW +: DW]   = srcq[i][0][DW-1:0];
                req_last[i]            = srcq[i][0][DW];
            end else begin
                req_valid[i]           = 1'b0;
                req_data[i*DW +: DW]   = DW'($urandom);
                req_last[i]            = 1'($urandom);
            end
        end
    endtask

    task automatic checkOutput();
        bit           ev;
        logic [N-1:0] er;
        ev = 1'b0;
        er = '0;
        if (m_busy) begin
            ev = req_valid[m_gnt];
            if (out_ready) er = N'(1) << m_gnt;
        end
        check("out_valid", 64'(out_valid), 64'(ev));
        check("req_ready", 64'(req_ready), 64'(er));
        check("out_id", 64'(out_id), 64'(m_gnt));
        check("out_last", 64'(out_last), 64'(m_busy ? req_last[m_gnt] : 1'b0));
        if (ev) check("out_data", 64'(out_data), 64'(srcq[m_gnt][0][DW-1:0]));
        if (out_valid && out_ready) begin
            dut_rx[out_id]++;
            dut_ids.push_back(int'(out_id));
        end
    endtask

    // Reference arbitration: search circularly starting just after the last winner.
    task automatic modelUpdate();
        if (m_busy) begin
            if (req_valid[m_gnt] && out_ready) begin
                if (srcq[m_gnt][0][DW]) m_busy = 1'b0;
                void'(srcq[m_gnt].pop_front());
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (req_valid[idx]) begin
                    m_gnt  = idx;
                    m_ptr  = idx;
                    m_busy = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic cycle();
        applyStimulus();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic cycles(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic checkIds(input string tag, input int exp_ids[$]);
        check({tag, "_count"}, 64'(dut_ids.size()), 64'(exp_ids.size()));
        for (int i = 0; i < exp_ids.size() && i < dut_ids.size(); i++) begin
            check(tag, 64'(dut_ids[i]), 64'(exp_ids[i]));
        end
    endtask

    initial begin
        logic [DW:0] hold;
        int          exp_ids [$];

        rst       = 1'b1;
        out_ready = 1'b1;
        en        = '1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        m_busy    = 1'b0;
        m_gnt     = 0;
        m_ptr     = N - 1;
        for (int i = 0; i < N; i++) begin
            sent[i]   = 0;
            dut_rx[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset state with requester 0 already waiting, then release.
        sendPacket(0, 1);
        applyStimulus();
        @(negedge clk);
        checkOutput();
        rst = 1'b0;
        @(posedge clk);
        modelUpdate();
        #1;
        cycles(2);
        exp_ids = '{0};
        checkIds("first_grant", exp_ids);

        // All requesters continuously valid: strict rotation with idle bubbles.
        dut_ids.delete();
        for (int i = 0; i < N; i++) begin
            sendPacket(i, 1);
            sendPacket(i, 1);
        end
        cycles(18);
        exp_ids = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        checkIds("rotation", exp_ids);
        cycles(16);

        // Wrap-around: after 5 wins, 2 beats 5 on the next round.
        sendPacket(5, 1);
        cycles(2);
        dut_ids.delete();
        sendPacket(2, 1);
        sendPacket(5, 1);
        cycles(4);
        exp_ids = '{2, 5};
        checkIds("wrap", exp_ids);

        // Lock: requester 3 pauses mid-packet while 1 waits.
        dut_ids.delete();
        sendPacket(3, 4);
        cycle();
        sendPacket(1, 1);
        cycles(2);
        en[3] = 1'b0;
        cycles(2);
        en[3] = 1'b1;
        cycles(4);
        exp_ids = '{3, 3, 3, 3, 1};
        checkIds("lock", exp_ids);

        // Downstream stall mid-packet.
        sendPacket(6, 4);
        cycles(2);
        out_ready = 1'b0;
        hold = srcq[6][0];
        for (int s = 0; s < 3; s++) begin
            cycle();
            check("stall_ready", 64'(req_ready), 64'(0));
            check("stall_data", 64'(out_data), 64'(hold[DW-1:0]));
        end
        out_ready = 1'b1;
        cycles(6);
        check("stall_beats", 64'(dut_rx[6]), 64'(sent[6]));

        // Random traffic, gaps and backpressure, then drain.
        for (int r = 0; r < 400; r++) begin
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() == 0 && $urandom_range(0, 3) == 0)
                    sendPacket(i, $urandom_range(1, 4));
            end
            en        = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        en        = '1;
        out_ready = 1'b1;
        cycles(200);
        for (int i = 0; i < N; i++) begin
            check("drain_empty", 64'(srcq[i].size()), 64'(0));
            check("beat_count", 64'(dut_rx[i]), 64'(sent[i]));
        end

        // Reset during beat 2 drops the packet and restores index-0 priority.
        sendPacket(4, 3);
        cycles(2);
        applyStimulus();
        #1;
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        rst = 1'b1;
        #1;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_id", 64'(out_id), 64'(0));
        m_busy = 1'b0;
        m_gnt  = 0;
        m_ptr  = N - 1;
        for (int i = 0; i < N; i++) srcq[i].delete();
        for (int i = 0; i < N; i++) sendPacket(i, 1);
        applyStimulus();
        @(negedge clk);
        checkOutput();
        rst = 1'b0;
        @(posedge clk);
        modelUpdate();
        #1;
        dut_ids.delete();
        cycles(3);
        exp_ids = '{0, 1};
        checkIds("post_rst", exp_ids);
        cycles(16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
